// File: rtl/fact_pkg.sv
// Shared constants and types for the iterative factorial engine.
// The control unit, its decoder and the datapath all take their widths and state codes from here.
package fact_pkg;

  localparam int N_W    = 4;
  localparam int MAX_N  = 12;
  localparam int PROD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    MULT  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  // One Moore control word per state.
  typedef struct packed {
    logic cnt_ld;
    logic cnt_en;
    logic prod_ld;
    logic prod_sel;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  // Codes 6 and 7 have no meaning.
  function automatic logic is_legal_state(input logic [2:0] code);
    return code <= 3'd5;
  endfunction

endpackage

// File: rtl/fact_cu_out_dec.sv
// Combinational state-to-control-word decoder for the factorial control unit.
// It is kept separate so that the GPIO debug readback can decode a captured state code the same way.
module fact_cu_out_dec
  import fact_pkg::*;
(
  input  logic [2:0] state,
  output logic       cnt_ld,
  output logic       cnt_en,
  output logic       prod_ld,
  output logic       prod_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  ctrl_t ctrl;

  // Illegal codes decode to an all-zero word, the same as IDLE.
  always_comb begin
    ctrl = '0;
    if (is_legal_state(state)) begin
      case (state)
        LOAD: begin
          ctrl.cnt_ld   = 1'b1;
          ctrl.prod_ld  = 1'b1;
          ctrl.prod_sel = 1'b0;
          ctrl.busy     = 1'b1;
        end
        CHECK: begin
          ctrl.busy = 1'b1;
        end
        MULT: begin
          ctrl.prod_ld  = 1'b1;
          ctrl.prod_sel = 1'b1;
          ctrl.cnt_en   = 1'b1;
          ctrl.busy     = 1'b1;
        end
        DONE: begin
          ctrl.done = 1'b1;
        end
        ERR: begin
          ctrl.err = 1'b1;
        end
        default: begin
          ctrl = '0;
        end
      endcase
    end
  end

  assign cnt_ld   = ctrl.cnt_ld;
  assign cnt_en   = ctrl.cnt_en;
  assign prod_ld  = ctrl.prod_ld;
  assign prod_sel = ctrl.prod_sel;
  assign busy     = ctrl.busy;
  assign done     = ctrl.done;
  assign err      = ctrl.err;

endmodule

// File: rtl/fact_cu.sv
// Control unit for the iterative factorial engine. It holds the state register and the next-state logic.
// The control word is a pure Moore decode of the state register.
module fact_cu
  import fact_pkg::*;
#(
  parameter int N_W   = fact_pkg::N_W,
  parameter int MAX_N = fact_pkg::MAX_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [N_W-1:0] n,
  input  logic           cnt_le_one,
  output logic           cnt_ld,
  output logic           cnt_en,
  output logic           prod_ld,
  output logic           prod_sel,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2:0]     state
);

  localparam logic [31:0] MAX_N_U = 32'(MAX_N);

  state_t state_r;
  state_t state_nx;
  logic   n_ok;

  // n is zero-extended, so this is an unsigned compare.
  assign n_ok = (32'(n) <= MAX_N_U);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (go) begin
          state_nx = n_ok ? LOAD : ERR;
        end
      end
      LOAD:  state_nx = CHECK;
      CHECK: state_nx = cnt_le_one ? DONE : MULT;
      MULT:  state_nx = CHECK;
      // Results stay on display until go is released, so a held go cannot restart the engine.
      DONE, ERR: begin
        if (!go) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign state = state_r;

  fact_cu_out_dec u_out_dec (
    .state    (state_r),
    .cnt_ld   (cnt_ld),
    .cnt_en   (cnt_en),
    .prod_ld  (prod_ld),
    .prod_sel (prod_sel),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

endmodule
